// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, issues word fetches over a req/gnt/rvalid handshake and
// buffers returned words in an in-order prefetch FIFO presented to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [CW-1:0] inflight, inflight_nxt;
  logic [CW-1:0] drop_cnt, drop_cnt_nxt;
  logic [CW-1:0] fifo_cnt, fifo_cnt_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] tag_rd, tag_wr;
  logic [31:0]   pc_q   [FIFO_DEPTH];
  logic [31:0]   inst_q [FIFO_DEPTH];
  logic [31:0]   tag_q  [FIFO_DEPTH];
  logic          grant, rsp, push, pop;

  always_comb begin
    pop  = (fifo_cnt != '0) && !stall_i && !branch_flag_i;
    rsp  = mem_rvalid_i && (inflight != '0);
    push = rsp && (drop_cnt == '0) && !branch_flag_i;

    // A slot freed by this cycle's pop is reusable at once; without that credit a
    // two-entry FIFO cannot sustain one word per cycle at single-cycle latency.
    mem_req_o  = (state == FETCH) && !branch_flag_i &&
                 ((inflight + fifo_cnt - CW'(pop)) < DEPTH_C);
    mem_addr_o = mem_req_o ? fetch_pc : '0;
    grant      = mem_req_o && mem_gnt_i;

    inflight_nxt = inflight + CW'(grant) - CW'(rsp);
    fifo_cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);
    fetch_pc_nxt = fetch_pc;
    drop_cnt_nxt = drop_cnt;
    state_nxt    = state;

    if (grant) begin
      fetch_pc_nxt = fetch_pc + 32'd4;
    end
    if (rsp && (drop_cnt != '0)) begin
      drop_cnt_nxt = drop_cnt - CW'(1);
    end

    unique case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   if (branch_flag_i && (inflight_nxt != '0)) state_nxt = DRAIN;
      DRAIN:   if (!branch_flag_i && (drop_cnt_nxt == '0)) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase

    // Every request still outstanding after this edge belongs to the old path.
    if (branch_flag_i) begin
      fetch_pc_nxt = branch_target_i & ~32'h3;
      drop_cnt_nxt = inflight_nxt;
      fifo_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      inflight <= inflight_nxt;
      drop_cnt <= drop_cnt_nxt;
      fifo_cnt <= fifo_cnt_nxt;
      if (branch_flag_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      // Tags track every outstanding request, stale ones included, so never flush.
      if (grant) tag_wr <= tag_wr + AW'(1);
      if (rsp)   tag_rd <= tag_rd + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      tag_q[tag_wr] <= fetch_pc;
    end
    if (push) begin
      pc_q[wr_ptr]   <= tag_q[tag_rd];
      inst_q[wr_ptr] <= mem_rdata_i;
    end
  end

  assign if_valid_o = (fifo_cnt != '0);
  assign if_pc_o    = if_valid_o ? pc_q[rd_ptr]   : '0;
  assign if_inst_o  = if_valid_o ? inst_q[rd_ptr] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (fifo_cnt == DEPTH_C)));

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
    !(mem_rvalid_i && (inflight == '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model with configurable latency, scoreboard
// of expected {pc, inst} per fetch path, plus a second instance exercising PC wrap-around.
module tb_if_fetch_unit;

  localparam logic [31:0] KEY     = 32'hA5A5_A5A5;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  logic        w_req, w_valid, w_rvalid;
  logic [31:0] w_addr, w_pc, w_inst, w_rdata;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
  );

  if_fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst), .stall_i(1'b0), .branch_flag_i(1'b0),
    .branch_target_i(32'h0), .mem_req_o(w_req), .mem_addr_o(w_addr),
    .mem_gnt_i(1'b1), .mem_rvalid_i(w_rvalid), .mem_rdata_i(w_rdata),
    .if_valid_o(w_valid), .if_pc_o(w_pc), .if_inst_o(w_inst)
  );

  // Always-grant, single-cycle memory for the wrap instance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_rvalid <= 1'b0;
      w_rdata  <= '0;
    end else begin
      w_rvalid <= w_req;
      w_rdata  <= w_addr ^ KEY;
    end
  end

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned ready;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } out_t;

  req_t        pending[$];
  out_t        sb[$];
  req_t        rsp_e;
  out_t        head;
  logic        have_rsp;
  int unsigned epoch = 0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_addr, w_exp_addr, w_exp_pc;
  logic        chk_valid_low = 1'b0;

  logic        k_stall = 1'b0, k_branch = 1'b0, k_gnt = 1'b0, k_rsp = 1'b1;
  logic [31:0] k_target = '0;
  int unsigned k_lat = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then score what the next rising edge does.
  task automatic step();
    @(negedge clk);
    cyc++;
    stall_i         = k_stall;
    branch_flag_i   = k_branch;
    branch_target_i = k_target;
    mem_gnt_i       = k_gnt;
    mem_rvalid_i    = 1'b0;
    mem_rdata_i     = '0;
    have_rsp        = 1'b0;
    if (k_rsp && (pending.size() != 0) && (pending[0].ready <= cyc)) begin
      rsp_e        = pending.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rsp_e.addr ^ KEY;
      have_rsp     = 1'b1;
    end
    #1;

    if (chk_valid_low) check("valid_after_branch", if_valid_o, 1'b0);
    chk_valid_low = 1'b0;
    if (!if_valid_o) begin
      check("idle_pc", if_pc_o, 32'h0);
      check("idle_inst", if_inst_o, 32'h0);
    end
    if (k_branch) check("req_in_branch", mem_req_o, 1'b0);

    if (if_valid_o && !k_stall && !k_branch) begin
      check("out_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        head = sb.pop_front();
        check("out_pc", if_pc_o, head.pc);
        check("out_inst", if_inst_o, head.inst);
      end
    end

    if (have_rsp && (rsp_e.epoch == epoch) && !k_branch)
      sb.push_back('{rsp_e.addr, rsp_e.addr ^ KEY});

    if (k_branch) begin
      sb.delete();
      epoch++;
      exp_addr      = k_target & ~32'h3;
      chk_valid_low = 1'b1;
    end

    if (mem_req_o && mem_gnt_i) begin
      check("req_addr", mem_addr_o, exp_addr);
      pending.push_back('{exp_addr, epoch, cyc + k_lat});
      exp_addr += 32'd4;
    end

    if (w_req) begin
      check("wrap_addr", w_addr, w_exp_addr);
      w_exp_addr += 32'd4;
    end
    if (w_valid) begin
      check("wrap_pc", w_pc, w_exp_pc);
      check("wrap_inst", w_inst, w_exp_pc ^ KEY);
      w_exp_pc += 32'd4;
    end
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b0;
    stall_i = 1'b0; branch_flag_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #1;
    check("rst_req", mem_req_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_valid", if_valid_o, 1'b0);
    check("rst_pc", if_pc_o, 32'h0);
    check("rst_inst", if_inst_o, 32'h0);
    check("rst_wrap_req", w_req, 1'b0);
    pending.delete();
    sb.delete();
    epoch++;
    exp_addr = 32'h0; w_exp_addr = WRAP_PC; w_exp_pc = WRAP_PC;
    k_stall = 1'b0; k_branch = 1'b0; k_gnt = 1'b1; k_rsp = 1'b1; k_lat = 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("boot_no_req", mem_req_o, 1'b0);
    step();
    check("first_req", mem_req_o, 1'b1);
    check("first_addr", mem_addr_o, 32'h0);
  endtask

  logic [31:0] held_pc, held_inst, bp_addr;

  initial begin
    apply_reset();

    // Streaming, one word per cycle once filled.
    repeat (2) step();
    for (int i = 0; i < 12; i++) begin
      step();
      check("no_bubble", if_valid_o, 1'b1);
    end

    // Stall: head held, request budget exhausted, resumes on release.
    k_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        held_pc = if_pc_o;
        held_inst = if_inst_o;
      end else begin
        check("stall_pc_hold", if_pc_o, held_pc);
        check("stall_inst_hold", if_inst_o, held_inst);
      end
      if (i >= 2) check("stall_req_low", mem_req_o, 1'b0);
    end
    k_stall = 1'b0;
    step();
    check("req_resume", mem_req_o, 1'b1);
    repeat (6) step();

    // Grant backpressure.
    k_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_req_held", mem_req_o, 1'b1);
      if (i == 0) bp_addr = mem_addr_o;
      else check("bp_addr_stable", mem_addr_o, bp_addr);
      if (i >= 2) check("bp_valid_low", if_valid_o, 1'b0);
    end
    k_gnt = 1'b1;
    repeat (6) step();

    // Branch landing on a cycle that also returns a word.
    k_branch = 1'b1; k_target = 32'h0000_2000;
    step();
    k_branch = 1'b0;
    repeat (8) step();

    // Branch with two requests outstanding; both stale words must be dropped.
    k_rsp = 1'b0;
    repeat (3) step();
    check("two_inflight", pending.size(), 32'd2);
    k_branch = 1'b1; k_target = 32'h0000_1003;
    step();
    k_branch = 1'b0; k_rsp = 1'b1;
    step();
    check("drain_no_req", mem_req_o, 1'b0);
    repeat (10) step();

    // Reset mid-stream with a request pending.
    check("req_before_rst", mem_req_o, 1'b1);
    apply_reset();
    repeat (8) step();

    // Let everything outstanding return and drain.
    k_gnt = 1'b0;
    repeat (6) step();
    check("sb_empty", sb.size(), 32'd0);
    check("pending_empty", pending.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
